// File: rtl/mem_responder.sv
// Wait-state memory responder: single-outstanding req/ack slave over a 32-bit word array.
// Optional address checking is enabled by defining MEM_RESPONDER_ERR_EN.
module mem_responder #(
  parameter int ADDR_WIDTH  = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  be,
  output logic        ack,
  output logic [31:0] rdata,
  output logic        err,
  output logic        busy
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                  state;
  logic [3:0]              cnt;
  logic                    wr_q;
  logic [ADDR_WIDTH-1:0]   idx_q;
  logic [31:0]             wdata_q;
  logic [3:0]              be_q;
  logic                    bad_q;
  logic                    addr_bad;
  logic                    access;
  logic                    do_write;
  logic [31:0]             mem [DEPTH];

`ifdef MEM_RESPONDER_ERR_EN
  assign addr_bad = (addr[1:0] != 2'b00) || (addr[31:ADDR_WIDTH+2] != '0);
`else
  // Byte-offset and upper bits are don't-care: the word index wraps over the array.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr[31:ADDR_WIDTH+2], addr[1:0]};
  assign addr_bad         = 1'b0;
`endif

  assign access   = (state == WAIT) && (cnt == 4'd0);
  assign do_write = access && wr_q && !bad_q;
  assign busy     = (state != IDLE);

  // NOTE: all state here is sequential, so every assignment is non-blocking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      ack     <= 1'b0;
      err     <= 1'b0;
      rdata   <= 32'h0;
      wr_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= 32'h0;
      be_q    <= 4'h0;
      bad_q   <= 1'b0;
    end else begin
      ack <= 1'b0;
      err <= 1'b0;
      case (state)
        // The RESP cycle doubles as an accept point so a held req streams
        // at one access every WAIT_CYCLES+2 cycles.
        IDLE, RESP: begin
          if (req) begin
            wr_q    <= wr;
            idx_q   <= addr[ADDR_WIDTH+1:2];
            wdata_q <= wdata;
            be_q    <= be;
            bad_q   <= addr_bad;
            cnt     <= 4'(WAIT_CYCLES);
            state   <= WAIT;
          end else begin
            state <= IDLE;
          end
        end
        WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            ack <= 1'b1;
            err <= bad_q;
            if (!wr_q && !bad_q) rdata <= mem[idx_q];
            state <= RESP;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: the array is deliberately left out of reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int i = 0; i < 4; i++) begin
        if (be_q[i]) mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Randomized bench for mem_responder: a transaction-level model predicts ack/busy/err/rdata
// every cycle; directed sequences pin latency, byte lanes, reset abort and addressing.
module tb_mem_responder;

  localparam int AW = 8;
  localparam int W  = 2;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        req   = 1'b0;
  logic        wr    = 1'b0;
  logic [31:0] addr  = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic [3:0]  be    = 4'h0;
  logic        ack, err, busy;
  logic [31:0] rdata;

  logic        req0   = 1'b0;
  logic        wr0    = 1'b0;
  logic [31:0] addr0  = 32'h0;
  logic [31:0] wdata0 = 32'h0;
  logic [3:0]  be0    = 4'h0;
  logic        ack0, err0, busy0;
  logic [31:0] rdata0;

  mem_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(W)) u_dut (
    .clk(clk), .rst_n(rst_n), .req(req), .wr(wr), .addr(addr), .wdata(wdata),
    .be(be), .ack(ack), .rdata(rdata), .err(err), .busy(busy)
  );

  mem_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .req(req0), .wr(wr0), .addr(addr0), .wdata(wdata0),
    .be(be0), .ack(ack0), .rdata(rdata0), .err(err0), .busy(busy0)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit cmp_on = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_mem [256];
  bit          m_active = 1'b0;
  int          m_start  = 0;
  int          edge_n   = 0;
  bit          m_wr;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_be;
  bit          exp_ack, exp_err, exp_busy;
  logic [31:0] exp_rdata = 32'h0;

  function automatic bit addr_bad(input logic [31:0] a);
`ifdef MEM_RESPONDER_ERR_EN
    return (a % 4 != 0) || ((a >> (AW + 2)) != 0);
`else
    return 1'b0;
`endif
  endfunction

  // A request sampled at edge k is serviced at edge k+W+1 and released at k+W+2,
  // where a still-asserted req is accepted as the next transaction.
  task automatic model_step();
    int idx;
    if (!rst_n) begin
      m_active  = 1'b0;
      exp_ack   = 1'b0;
      exp_err   = 1'b0;
      exp_busy  = 1'b0;
      exp_rdata = 32'h0;
      return;
    end
    exp_ack = 1'b0;
    exp_err = 1'b0;
    if (m_active && edge_n == m_start + W + 1) begin
      idx     = int'((m_addr / 4) % 256);
      exp_ack = 1'b1;
      exp_err = addr_bad(m_addr);
      if (!exp_err) begin
        if (m_wr) begin
          for (int i = 0; i < 4; i++)
            if (m_be[i]) m_mem[idx][8*i +: 8] = m_wdata[8*i +: 8];
        end else begin
          exp_rdata = m_mem[idx];
        end
      end
    end else if (m_active && edge_n == m_start + W + 2) begin
      m_active = 1'b0;
    end
    if (!m_active && req) begin
      m_active = 1'b1;
      m_start  = edge_n;
      m_wr     = wr;
      m_addr   = addr;
      m_wdata  = wdata;
      m_be     = be;
    end
    exp_busy = m_active;
    edge_n++;
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (cmp_on) begin
      check("cyc_ack", ack, exp_ack);
      check("cyc_busy", busy, exp_busy);
      check("cyc_rdata", rdata, exp_rdata);
      if (exp_ack) check("cyc_err", err, exp_err);
    end
  end

  // ---------------- driver ----------------
  // Called just after a rising edge; returns just after the ack edge.
  task automatic txn(input bit w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] b, input bit keep_req, input bit scramble);
    int n;
    req = 1'b1; wr = w; addr = a; wdata = d; be = b;
    @(posedge clk); #1;
    if (scramble) begin
      addr  = $urandom;
      wdata = $urandom;
      be    = 4'($urandom);
      wr    = 1'($urandom);
    end
    n = 0;
    while (ack !== 1'b1 && n < 64) begin
      @(posedge clk); #1;
      n++;
    end
    check("txn_ack_seen", ack, 1);
    if (!keep_req) req = 1'b0;
  endtask

  logic [4:0] ack_bits, busy_bits;
  logic [5:0] ack0_bits, busy0_bits;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    cmp_on = 1'b1;
    check("rst_ack", ack, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_rdata", rdata, 0);

    // First request right after reset release, full-word write.
    rst_n = 1'b1;
    req = 1'b1; wr = 1'b1; addr = 32'h10; wdata = 32'hDEADBEEF; be = 4'hF;
    for (int e = 0; e < 5; e++) begin
      @(posedge clk); #1;
      ack_bits[e]  = ack;
      busy_bits[e] = busy;
      if (ack) req = 1'b0;
    end
    check("first_ack_edges", ack_bits, 5'b01000);
    check("first_busy_edges", busy_bits, 5'b01111);

    txn(0, 32'h10, 32'h0, 4'h0, 0, 0);
    check("read_deadbeef", rdata, 32'hDEADBEEF);

    txn(1, 32'h10, 32'h000000AA, 4'b0001, 0, 0);
    check("rdata_kept_by_write", rdata, 32'hDEADBEEF);
    txn(0, 32'h10, 32'h0, 4'h0, 0, 0);
    check("read_lane0", rdata, 32'hDEADBEAA);

    txn(1, 32'h10, 32'hFFFFFFFF, 4'h0, 0, 0);
    txn(0, 32'h10, 32'h0, 4'h0, 0, 0);
    check("read_be0", rdata, 32'hDEADBEAA);

    // Inputs scrambled mid-WAIT must not affect the latched write.
    txn(1, 32'h40, 32'hCAFEF00D, 4'hF, 0, 1);
    txn(0, 32'h40, 32'h0, 4'h0, 0, 0);
    check("read_latched", rdata, 32'hCAFEF00D);

    // Reset in WAIT aborts the write.
    txn(1, 32'h20, 32'h11112222, 4'hF, 0, 0);
    req = 1'b1; wr = 1'b1; addr = 32'h20; wdata = 32'hFFFFFFFF; be = 4'hF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    req   = 1'b0;
    #1;
    check("abort_ack", ack, 0);
    check("abort_busy", busy, 0);
    check("abort_err", err, 0);
    check("abort_rdata", rdata, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    txn(0, 32'h20, 32'h0, 4'h0, 0, 0);
    check("read_after_abort", rdata, 32'h11112222);

    // Misaligned address handling.
    txn(1, 32'h10, 32'h12345678, 4'hF, 0, 0);
    txn(1, 32'h44, 32'h0BADF00D, 4'hF, 0, 0);
    txn(0, 32'h44, 32'h0, 4'h0, 0, 0);
    check("read_0x44", rdata, 32'h0BADF00D);
    txn(0, 32'h13, 32'h0, 4'h0, 0, 0);
`ifdef MEM_RESPONDER_ERR_EN
    check("misaligned_err", err, 1);
    check("misaligned_rdata", rdata, 32'h0BADF00D);
`else
    check("misaligned_err", err, 0);
    check("misaligned_rdata", rdata, 32'h12345678);
`endif

    // Fill the whole array back-to-back, then random traffic.
    for (int i = 0; i < 256; i++) txn(1, i << 2, $urandom, 4'hF, 1, 0);
    for (int t = 0; t < 400; t++) begin
      logic [31:0] a;
`ifdef MEM_RESPONDER_ERR_EN
      a = ($urandom_range(0, 7) == 0) ? $urandom : ($urandom_range(0, 255) << 2);
`else
      a = $urandom;
`endif
      txn(1'($urandom), a, $urandom, 4'($urandom), 1'($urandom), $urandom_range(0, 3) == 0);
      if (!req) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    req = 1'b0;
    repeat (4) begin @(posedge clk); #1; end

    // Zero wait states: one write, then reads with req held high.
    req0 = 1'b1; wr0 = 1'b1; addr0 = 32'h0; wdata0 = 32'h5A5A5A5A; be0 = 4'hF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("w0_write_ack", ack0, 1);
    req0 = 1'b0; wr0 = 1'b0;
    @(posedge clk); #1;
    req0 = 1'b1;
    for (int e = 0; e < 6; e++) begin
      @(posedge clk); #1;
      ack0_bits[e]  = ack0;
      busy0_bits[e] = busy0;
    end
    req0 = 1'b0;
    check("w0_ack_edges", ack0_bits, 6'b101010);
    check("w0_busy_edges", busy0_bits, 6'b111111);
    check("w0_rdata", rdata0, 32'h5A5A5A5A);
    check("w0_err", err0, 0);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
